cycle_event_gen: RTL and testbench
==================================

CYCLE_EVENT_GEN -- requirements
Module: cycle_event_gen

Interface
REQ-001 Parameter NCH, default 4: number of divider/event channels, 1..16.
REQ-002 Parameter CNT_W, default 32: cycle counter width, 4..64.
REQ-003 Parameter DIV_W, default 16: divide-ratio width, 2..32.
REQ-004 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1: asynchronous, active-high reset.
REQ-006 Port en, input, 1: global count enable; 0 freezes all counters.
REQ-007 Port cfg_valid, input, 1: configuration write request.
REQ-008 Port cfg_ready, output, 1: configuration write may be accepted this cycle.
REQ-009 Port cfg_ch, input, max(1,$clog2(NCH+1)): target channel index.
REQ-010 Port cfg_div, input, DIV_W: divide ratio; 0 disables that channel's divider.
REQ-011 Port cfg_match, input, CNT_W: cycle value for the channel's one-shot event.
REQ-012 Port cfg_err, output, 1: one-cycle pulse; accepted write had cfg_ch >= NCH.
REQ-013 Port cycle, output, CNT_W: free-running cycle count.
REQ-014 Port wrap, output, 1: one-cycle pulse after cycle wraps from all-ones to 0.
REQ-015 Port tick, output, NCH: per-channel one-cycle divider pulse.
REQ-016 Port div_clk, output, NCH: per-channel divided square wave, toggling on each tick.
REQ-017 Port match_evt, output, NCH: per-channel one-shot match pulse.

Function
REQ-018 Write acceptance SHALL be cfg_valid && cfg_ready, sampled at the rising edge.
REQ-019 After each accepted write, cfg_ready SHALL deassert for exactly one cycle, then reassert; it is otherwise 1.
REQ-020 An accepted write to channel i < NCH SHALL load div[i] and match[i], clear dcnt[i] and div_clk[i], set armed[i], and clear tick[i]/match_evt[i] on that edge.
REQ-021 An accepted write with cfg_ch >= NCH SHALL change no state and pulse cfg_err for one cycle.
REQ-022 When en=1, cycle SHALL increment by 1 per edge, wrapping from 2^CNT_W-1 to 0; wrap SHALL be high for the cycle following the wrapping edge.
REQ-023 With en=1 and div[i]!=0: if dcnt[i]==div[i]-1, then dcnt[i] SHALL be set to 0, tick[i] SHALL be 1 for the next cycle, and div_clk[i] SHALL toggle; otherwise dcnt[i] SHALL increment.
REQ-024 div[i]=1 SHALL produce tick[i] high continuously and div_clk[i] toggling every edge.
REQ-025 div[i]=0 SHALL hold tick[i]=0, div_clk[i] at its current value, and dcnt[i] at 0.
REQ-026 With en=1, armed[i]=1, and the pre-increment cycle==match[i], match_evt[i] SHALL be 1 for the next cycle and armed[i] SHALL clear; no refire until rewritten, including across wraps.
REQ-027 A write to channel i SHALL take precedence over a same-edge tick or match of channel i; that tick or match is suppressed, and the new values apply from the following edge.
REQ-028 en=0 SHALL hold cycle, dcnt, div_clk, and armed, and drive tick, match_evt, and wrap to 0; configuration writes SHALL still be accepted.
REQ-029 All outputs SHALL be registered, with no combinational input-to-output paths.
REQ-030 Output latency SHALL be one cycle from the qualifying edge to the pulse.

Reset
REQ-031 Asserting reset SHALL immediately, without a clock, drive cycle, wrap, tick, div_clk, match_evt, cfg_err, and cfg_ready to 0.
REQ-032 Asserting reset SHALL clear all div, match, dcnt, and armed state to 0, so all channels are disabled.
REQ-033 cfg_ready SHALL become 1 at the first rising edge after reset deasserts.
REQ-034 Reset asserted mid-operation SHALL abort all counting and discard pending pulses, with no partial-update residue.

Verification
REQ-035 Reset; write ch0 div=10; en=1 -> tick[0] pulses every 10 cycles; div_clk[0] has a 20-cycle period, first rising 10 cycles after the write takes effect.
REQ-036 CNT_W=4; write ch1 div=0 match=5 at cycle=0 -> single match_evt[1] pulse in the cycle after cycle=5; wrap pulses after 15->0; no second match_evt[1].
REQ-037 cfg_valid held high for 2 writes (ch0 div=3, ch2 div=4) -> first accepted, cfg_ready=0 one cycle, second accepted on the next edge; both channels tick at their ratios.
REQ-038 NCH=3; write cfg_ch=3 -> cfg_err one-cycle pulse; cycle, tick, and div_clk are unchanged.
REQ-039 ch0 div=4 running; en=0 for 5 cycles mid-count -> cycle and dcnt frozen, tick=0; after en=1, the next tick comes exactly the remaining count later.
REQ-040 Assert reset between clock edges while ticking -> all outputs are 0 before the next edge; after release, no tick occurs until a channel is rewritten.

Source files
------------

// File: rtl/cycle_event_gen.sv
// cycle_event_gen
//   Free-running cycle counter with NCH independent divider/event channels.
//   Each channel holds a divide ratio (periodic tick + divided square wave)
//   and a one-shot match value compared against the cycle counter.
//
// Ports
//   clk        - single clock, all state updates on rising edge
//   reset      - asynchronous, active-high
//   en         - global count enable; 0 freezes cycle/divider/arm state
//   cfg_valid  - configuration write request
//   cfg_ready  - write may be accepted this cycle (drops for one cycle after each accept)
//   cfg_ch     - target channel index; values >= NCH are rejected with cfg_err
//   cfg_div    - divide ratio, 0 disables the channel's divider
//   cfg_match  - cycle value for the channel's one-shot event
//   cfg_err    - one-cycle pulse after a write to a nonexistent channel
//   cycle      - free-running cycle count
//   wrap       - one-cycle pulse after cycle wraps from all-ones to 0
//   tick       - per-channel one-cycle divider pulse
//   div_clk    - per-channel divided square wave, toggles on each tick
//   match_evt  - per-channel one-shot match pulse
module cycle_event_gen #(
  parameter int unsigned NCH   = 4,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned DIV_W = 16,
  localparam int unsigned CH_W = ($clog2(NCH + 1) > 1) ? $clog2(NCH + 1) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_match,
  output logic             cfg_err,
  output logic [CNT_W-1:0] cycle,
  output logic             wrap,
  output logic [NCH-1:0]   tick,
  output logic [NCH-1:0]   div_clk,
  output logic [NCH-1:0]   match_evt
);

  typedef enum logic [1:0] {
    ST_INIT,   // held in reset / first cycle after release: not ready
    ST_READY,  // accepting writes
    ST_HOLD    // one-cycle gap after an accepted write
  } cfg_state_t;

  cfg_state_t state, state_nxt;
  logic       cfg_acc;
  logic       ch_ok;

  assign cfg_acc = cfg_valid && cfg_ready;
  assign ch_ok   = (cfg_ch < CH_W'(NCH));

  // Configuration handshake FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_INIT;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_INIT:  state_nxt = ST_READY;
      ST_READY: if (cfg_valid) state_nxt = ST_HOLD;
      ST_HOLD:  state_nxt = ST_READY;
      default:  state_nxt = ST_INIT;
    endcase
  end

  // Decoded directly from the state register, so no input reaches it
  always_comb begin
    cfg_ready = (state == ST_READY);
  end

  // Cycle counter, wrap pulse and write-error pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cycle   <= '0;
      wrap    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_acc && !ch_ok;
      if (en) begin
        cycle <= cycle + CNT_W'(1);
        wrap  <= (cycle == '1);
      end else begin
        wrap  <= 1'b0;
      end
    end
  end

  // Per-channel divider and one-shot match
  for (genvar g = 0; g < NCH; g++) begin : g_ch
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] dcnt_r;
    logic [CNT_W-1:0] match_r;
    logic             armed_r;
    logic             tick_r;
    logic             dclk_r;
    logic             evt_r;
    logic             wr_sel;
    logic             div_last;

    assign wr_sel = cfg_acc && (cfg_ch == CH_W'(g));

    always_comb begin
      div_last = (dcnt_r == div_r - DIV_W'(1));
    end

    // A write to this channel wins over any tick/match due on the same edge
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        div_r   <= '0;
        dcnt_r  <= '0;
        match_r <= '0;
        armed_r <= 1'b0;
        tick_r  <= 1'b0;
        dclk_r  <= 1'b0;
        evt_r   <= 1'b0;
      end else if (wr_sel) begin
        div_r   <= cfg_div;
        match_r <= cfg_match;
        dcnt_r  <= '0;
        dclk_r  <= 1'b0;
        armed_r <= 1'b1;
        tick_r  <= 1'b0;
        evt_r   <= 1'b0;
      end else if (en) begin
        if (div_r == '0) begin
          dcnt_r <= '0;
          tick_r <= 1'b0;
        end else if (div_last) begin
          dcnt_r <= '0;
          tick_r <= 1'b1;
          dclk_r <= ~dclk_r;
        end else begin
          dcnt_r <= dcnt_r + DIV_W'(1);
          tick_r <= 1'b0;
        end
        // Compared against the pre-increment cycle value
        if (armed_r && (cycle == match_r)) begin
          evt_r   <= 1'b1;
          armed_r <= 1'b0;
        end else begin
          evt_r   <= 1'b0;
        end
      end else begin
        tick_r <= 1'b0;
        evt_r  <= 1'b0;
      end
    end

    assign tick[g]      = tick_r;
    assign div_clk[g]   = dclk_r;
    assign match_evt[g] = evt_r;
  end

endmodule

// File: tb/tb_cycle_event_gen.sv
module tb_cycle_event_gen;

  localparam int unsigned NCH     = 3;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned DIV_W   = 6;
  localparam int unsigned CH_W    = 2;
  localparam int unsigned CYC_MOD = 1 << CNT_W;

  logic             clk;
  logic             reset;
  logic             en;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_match;
  logic             cfg_err;
  logic [CNT_W-1:0] cycle;
  logic             wrap;
  logic [NCH-1:0]   tick;
  logic [NCH-1:0]   div_clk;
  logic [NCH-1:0]   match_evt;

  cycle_event_gen #(.NCH(NCH), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_match (cfg_match),
    .cfg_err   (cfg_err),
    .cycle     (cycle),
    .wrap      (wrap),
    .tick      (tick),
    .div_clk   (div_clk),
    .match_evt (match_evt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [CNT_W-1:0] cycle;
    logic             wrap;
    logic [NCH-1:0]   tick;
    logic [NCH-1:0]   div_clk;
    logic [NCH-1:0]   match_evt;
    logic             cfg_err;
    logic             cfg_ready;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_x;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: channel behaviour expressed as "enabled edges since
  // the last write" (m_k), ticks at every multiple of the ratio.
  int unsigned m_div   [NCH];
  int unsigned m_match [NCH];
  int unsigned m_k     [NCH];
  bit          m_armed [NCH];
  bit          m_dclk  [NCH];
  int unsigned m_cyc;
  bit          m_ready;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Apply one cycle of inputs and push the expected outputs after the next edge
  task automatic drive(input bit rst, input bit e, input bit v, input int unsigned ch,
                       input int unsigned d, input int unsigned mt);
    exp_t x;
    bit   acc;
    reset     = rst;
    en        = e;
    cfg_valid = v;
    cfg_ch    = CH_W'(ch);
    cfg_div   = DIV_W'(d);
    cfg_match = CNT_W'(mt);
    x.cycle = '0; x.wrap = 1'b0; x.tick = '0; x.div_clk = '0;
    x.match_evt = '0; x.cfg_err = 1'b0; x.cfg_ready = 1'b0;
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_div[i] = 0; m_match[i] = 0; m_k[i] = 0; m_armed[i] = 0; m_dclk[i] = 0;
      end
      m_cyc   = 0;
      m_ready = 0;
    end else begin
      acc       = v && m_ready;
      x.cfg_err = acc && (ch >= NCH);
      x.wrap    = e && (m_cyc == CYC_MOD - 1);
      for (int i = 0; i < NCH; i++) begin
        if (acc && ch == i) begin
          m_div[i] = d; m_match[i] = mt; m_k[i] = 0; m_dclk[i] = 0; m_armed[i] = 1;
        end else if (e) begin
          if (m_div[i] != 0) begin
            m_k[i]++;
            x.tick[i] = (m_k[i] % m_div[i]) == 0;
            m_dclk[i] = ((m_k[i] / m_div[i]) % 2) == 1;
          end
          if (m_armed[i] && m_cyc == m_match[i]) begin
            x.match_evt[i] = 1'b1;
            m_armed[i] = 0;
          end
        end
        x.div_clk[i] = m_dclk[i];
      end
      if (e) m_cyc = (m_cyc + 1) % CYC_MOD;
      x.cycle     = CNT_W'(m_cyc);
      m_ready     = !acc;
      x.cfg_ready = m_ready;
    end
    sb_q.push_back(x);
  endtask

  task automatic idle(input int n, input bit e);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive(0, e, 0, 0, 0, 0);
    end
  endtask

  // Holds cfg_valid until the model sees the write accepted
  task automatic write(input int unsigned ch, input int unsigned d, input int unsigned mt, input bit e);
    bit done = 0;
    for (int i = 0; i < 4 && !done; i++) begin
      @(negedge clk);
      done = m_ready;
      drive(0, e, 1, ch, d, mt);
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL write_timeout: ch %0d not accepted within 4 cycles", ch);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_cycle"},     64'(cycle),     64'(0));
    chk({tag, "_wrap"},      64'(wrap),      64'(0));
    chk({tag, "_tick"},      64'(tick),      64'(0));
    chk({tag, "_div_clk"},   64'(div_clk),   64'(0));
    chk({tag, "_match_evt"}, 64'(match_evt), 64'(0));
    chk({tag, "_cfg_err"},   64'(cfg_err),   64'(0));
    chk({tag, "_cfg_ready"}, 64'(cfg_ready), 64'(0));
  endtask

  // Monitor: compares DUT outputs after each edge against the scoreboard head
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (sb_q.size() > 0) begin
        mon_x = sb_q.pop_front();
        chk("cycle",     64'(cycle),     64'(mon_x.cycle));
        chk("wrap",      64'(wrap),      64'(mon_x.wrap));
        chk("tick",      64'(tick),      64'(mon_x.tick));
        chk("div_clk",   64'(div_clk),   64'(mon_x.div_clk));
        chk("match_evt", 64'(match_evt), 64'(mon_x.match_evt));
        chk("cfg_err",   64'(cfg_err),   64'(mon_x.cfg_err));
        chk("cfg_ready", 64'(cfg_ready), 64'(mon_x.cfg_ready));
      end
    end
  end

  initial begin
    int unsigned r;
    int unsigned d;
    reset = 1'b1; en = 1'b0; cfg_valid = 1'b0;
    cfg_ch = '0; cfg_div = '0; cfg_match = '0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      drive(1, 0, 0, 0, 0, 0);
    end
    idle(2, 0);

    // ch0 divide by 10
    write(0, 10, 15, 1);
    idle(45, 1);

    // back-to-back writes with cfg_valid held high
    write(0, 3, 15, 1);
    write(2, 4, 15, 1);
    idle(20, 1);

    // one-shot match on ch1 written as cycle goes to 0, observed across wraps
    for (int i = 0; i < 20 && m_cyc != CYC_MOD - 1; i++) idle(1, 1);
    write(1, 0, 5, 1);
    idle(40, 1);

    // write to nonexistent channel
    write(3, 7, 7, 1);
    idle(3, 1);

    // en pause mid-count
    write(0, 4, 15, 1);
    idle(2, 1);
    idle(5, 0);
    idle(10, 1);

    // asynchronous reset between edges while ticking
    write(0, 1, 15, 1);
    idle(3, 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    drive(1, 1, 0, 0, 0, 0);
    @(negedge clk);
    drive(1, 1, 0, 0, 0, 0);
    idle(12, 1);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      r = $urandom_range(0, 199);
      d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : $urandom_range(2, 12);
      if (r == 0)
        drive(1, 1, 0, 0, 0, 0);
      else
        drive(0, $urandom_range(0, 9) != 0, r < 30, $urandom_range(0, 3), d, $urandom_range(0, 15));
    end

    idle(2, 1);
    @(posedge clk);
    #3;
    chk("sb_drain", 64'(sb_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
